// File: rtl/interpolating_lut_channel_arbiter_if.sv
// Channel and LUT-core stream bundle for the interpolating LUT arbiter.
// master = arbiter side, slave = channel sources/sinks and the LUT core.
interface interpolating_lut_channel_arbiter_if #(
    parameter int G_NUM_CH = 4,
    parameter int G_DWIDTH = 24
);
    logic [G_NUM_CH*G_DWIDTH-1:0] ch_din;
    logic [G_NUM_CH-1:0]          ch_din_valid;
    logic [G_NUM_CH-1:0]          ch_din_ready;
    logic [G_NUM_CH*G_DWIDTH-1:0] ch_dout;
    logic [G_NUM_CH-1:0]          ch_dout_valid;
    logic [G_NUM_CH-1:0]          ch_dout_ready;
    logic [G_DWIDTH-1:0]          lut_din;
    logic                         lut_din_valid;
    logic                         lut_din_ready;
    logic [G_DWIDTH-1:0]          lut_dout;
    logic                         lut_dout_valid;
    logic                         lut_dout_ready;

    modport master (
        input  ch_din, ch_din_valid, ch_dout_ready,
        input  lut_din_ready, lut_dout, lut_dout_valid,
        output ch_din_ready, ch_dout, ch_dout_valid,
        output lut_din, lut_din_valid, lut_dout_ready
    );

    modport slave (
        output ch_din, ch_din_valid, ch_dout_ready,
        output lut_din_ready, lut_dout, lut_dout_valid,
        input  ch_din_ready, ch_dout, ch_dout_valid,
        input  lut_din, lut_din_valid, lut_dout_ready
    );
endinterface

// File: rtl/interpolating_lut_channel_arbiter.sv
// Round-robin sharing of one interpolating-LUT core among G_NUM_CH
// sample streams, one sample in flight, results routed back by channel.
module interpolating_lut_channel_arbiter #(
    parameter int G_NUM_CH    = 4,
    parameter int G_DWIDTH    = 24,
    parameter int G_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        lut_prog_done,
    interpolating_lut_channel_arbiter_if.master io,
    output logic [$clog2(G_NUM_CH)-1:0] active_ch,
    output logic                        busy,
    output logic [G_CNT_WIDTH-1:0]      xfer_count
);
    localparam int CW = $clog2(G_NUM_CH);

    typedef enum logic [2:0] {
        S_WAIT_PROG,
        S_ARB,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [CW-1:0]                last_grant;
    logic [CW-1:0]                grant;
    logic                         grant_found;
    logic [CW:0]                  cand;
    logic [G_DWIDTH-1:0]          sample;
    logic [G_NUM_CH*G_DWIDTH-1:0] dout_q;
    logic                         run;

    assign run        = enable && !reset;
    assign io.lut_din = sample;
    assign io.ch_dout = dout_q;

    // Search starts one past the last served channel; cand wraps at G_NUM_CH.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int i = 1; i <= G_NUM_CH; i++) begin
            cand = {1'b0, last_grant} + (CW+1)'(i);
            if (cand >= (CW+1)'(G_NUM_CH))
                cand = cand - (CW+1)'(G_NUM_CH);
            if (!grant_found && io.ch_din_valid[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant       = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        io.ch_din_ready   = '0;
        io.lut_din_valid  = 1'b0;
        io.lut_dout_ready = 1'b0;
        io.ch_dout_valid  = '0;
        busy              = 1'b0;
        unique case (state)
            S_WAIT_PROG: begin
                if (lut_prog_done)
                    state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!lut_prog_done) begin
                    state_nxt = S_WAIT_PROG;
                end else if (grant_found) begin
                    io.ch_din_ready[grant] = run;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy             = 1'b1;
                io.lut_din_valid = run;
                if (io.lut_din_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy              = 1'b1;
                io.lut_dout_ready = run;
                if (io.lut_dout_valid)
                    state_nxt = S_DELIVER;
            end
            S_DELIVER: begin
                busy = 1'b1;
                io.ch_dout_valid[active_ch] = run;
                if (io.ch_dout_ready[active_ch])
                    state_nxt = S_ARB;
            end
            default: state_nxt = S_WAIT_PROG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            state      <= S_WAIT_PROG;
            last_grant <= CW'(G_NUM_CH - 1);
            active_ch  <= '0;
            xfer_count <= '0;
            sample     <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_ARB && lut_prog_done && grant_found) begin
                sample    <= io.ch_din[grant*G_DWIDTH +: G_DWIDTH];
                active_ch <= grant;
            end
            if (state == S_DELIVER && io.ch_dout_ready[active_ch]) begin
                last_grant <= active_ch;
                xfer_count <= xfer_count + G_CNT_WIDTH'(1);
            end
        end
    end

    // Results survive enable=0; only a real reset clears them.
    always_ff @(posedge clk) begin
        if (reset)
            dout_q <= '0;
        else if (enable && state == S_WAIT && io.lut_dout_valid)
            dout_q[active_ch*G_DWIDTH +: G_DWIDTH] <= io.lut_dout;
    end
endmodule

// File: tb/tb_interpolating_lut_channel_arbiter.sv
// Directed and randomized checks of the LUT channel arbiter against
// a round-robin reference model and a behavioural LUT core.
module tb_interpolating_lut_channel_arbiter;
    localparam int N  = 4;
    localparam int DW = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        lut_prog_done;
    logic [1:0]  active_ch;
    logic        busy;
    logic [15:0] xfer_count;

    always #5 clk = ~clk;

    interpolating_lut_channel_arbiter_if #(.G_NUM_CH(N), .G_DWIDTH(DW)) bus ();

    interpolating_lut_channel_arbiter #(
        .G_NUM_CH(N), .G_DWIDTH(DW), .G_CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .lut_prog_done(lut_prog_done),
        .io(bus),
        .active_ch(active_ch),
        .busy(busy),
        .xfer_count(xfer_count)
    );

    // behavioural LUT core: identity or inverting, configurable latency
    logic core_busy;
    int   core_cnt;
    int   core_lat;
    bit   core_inv;
    bit   core_kill;

    assign bus.lut_din_ready = !core_busy;

    always @(posedge clk) begin
        if (core_kill) begin
            core_busy          <= 1'b0;
            core_cnt           <= 0;
            bus.lut_dout_valid <= 1'b0;
            bus.lut_dout       <= '0;
        end else if (!core_busy) begin
            if (bus.lut_din_valid) begin
                core_busy    <= 1'b1;
                core_cnt     <= core_lat;
                bus.lut_dout <= core_inv ? ~bus.lut_din : bus.lut_din;
            end
        end else if (!bus.lut_dout_valid) begin
            if (core_cnt <= 1) bus.lut_dout_valid <= 1'b1;
            else core_cnt <= core_cnt - 1;
        end else if (bus.lut_dout_ready) begin
            bus.lut_dout_valid <= 1'b0;
            core_busy          <= 1'b0;
        end
    end

    int n_chk;
    int n_pass;
    int n_fail;

    int             m_last;
    int             m_count;
    logic [DW-1:0]  exp_dout [N];
    logic [N-1:0]   vmask;
    logic [N-1:0]   pmask;
    logic [N-1:0]   late_mask;
    bit             refill;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(int last, logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] pack_exp();
        logic [N*DW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = exp_dout[c];
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            if (bus.ch_din_ready != '0) ok = 1'b1;
            else step();
        end
    endtask

    task automatic do_txn(input int hold, input bit drop_done);
        int            eg;
        bit            ok;
        logic [DW-1:0] d;
        logic [DW-1:0] r;
        logic [N-1:0]  oh;
        bus.ch_din_valid = vmask;
        #1;
        eg = next_grant(m_last, vmask);
        oh = N'(1) << eg;
        wait_ready(ok);
        chk("grant_seen", 128'(ok), 128'(1));
        if (!ok || eg < 0) return;
        chk("grant", 128'(bus.ch_din_ready), 128'(oh));
        d = bus.ch_din[eg*DW +: DW];
        step();
        chk("lut_din", 128'({bus.lut_din_valid, bus.lut_din}), 128'({1'b1, d}));
        chk("active_ch", 128'(active_ch), 128'(eg));
        if (!pmask[eg]) vmask[eg] = 1'b0;
        else if (refill) bus.ch_din[eg*DW +: DW] = DW'($urandom);
        vmask = vmask | late_mask;
        late_mask = '0;
        bus.ch_din_valid = vmask;
        if (drop_done) begin
            step();
            lut_prog_done = 1'b0;
        end
        r = core_inv ? ~d : d;
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            if (bus.ch_dout_valid != '0) ok = 1'b1;
            else step();
        end
        chk("dout_seen", 128'(ok), 128'(1));
        if (!ok) return;
        exp_dout[eg] = r;
        chk("dout_valid", 128'(bus.ch_dout_valid), 128'(oh));
        chk("dout_data", 128'(bus.ch_dout), 128'(pack_exp()));
        chk("busy", 128'(busy), 128'(1));
        if (hold > 0) begin
            bus.ch_dout_ready = ~oh;
            for (int h = 0; h < hold; h++) begin
                step();
                chk("hold_ctl",
                    128'({bus.ch_dout_valid, bus.ch_din_ready, bus.lut_din_valid}),
                    128'({oh, N'(0), 1'b0}));
                chk("hold_data", 128'(bus.ch_dout), 128'(pack_exp()));
            end
            bus.ch_dout_ready = '1;
        end
        step();
        m_last  = eg;
        m_count = m_count + 1;
        chk("xfer_count", 128'(xfer_count), 128'(m_count % 65536));
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_count = 0;
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_ctl"},
            128'({bus.ch_din_ready, bus.lut_din_valid, bus.lut_dout_ready,
                  bus.ch_dout_valid, busy, active_ch}),
            128'(0));
        chk({tag, "_count"}, 128'(xfer_count), 128'(0));
    endtask

    initial begin
        bit ok;
        n_chk = 0; n_pass = 0; n_fail = 0;
        reset = 1'b1; enable = 1'b1; lut_prog_done = 1'b0;
        bus.ch_din = '0; bus.ch_din_valid = '0; bus.ch_dout_ready = '1;
        core_kill = 1'b1; core_lat = 2; core_inv = 1'b0;
        vmask = '0; pmask = '1; late_mask = '0; refill = 1'b0;
        for (int c = 0; c < N; c++) exp_dout[c] = '0;
        model_reset();
        repeat (3) step();
        core_kill = 1'b0;
        chk_idle_outputs("reset");
        chk("reset_dout", 128'(bus.ch_dout), 128'(0));
        reset = 1'b0;

        // table not programmed: nothing may be accepted
        vmask = '1;
        bus.ch_din_valid = vmask;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("prog_gate", 128'({bus.ch_din_ready, bus.lut_din_valid}), 128'(0));
        end

        // directed round: fixed data, identity core, order 0,1,2,3,0
        for (int c = 0; c < N; c++) bus.ch_din[c*DW +: DW] = DW'((c + 1) * 24'h100);
        lut_prog_done = 1'b1;
        for (int i = 0; i < 4; i++) do_txn(0, 0);
        chk("round_count", 128'(xfer_count), 128'(4));
        chk("identity", 128'(bus.ch_dout), 128'(bus.ch_din));
        do_txn(0, 0);

        // single requester, then late arrivals must not be starved
        refill = 1'b1;
        vmask = 4'b0100;
        repeat (3) do_txn(0, 0);
        late_mask = 4'b0010;
        do_txn(0, 0);
        do_txn(0, 0);
        late_mask = 4'b1000;
        do_txn(0, 0);
        do_txn(0, 0);

        // back-pressure on channel 1
        vmask = 4'b0010;
        do_txn(10, 0);

        // programming-done drops while the core is working
        vmask = '1;
        do_txn(0, 1);
        for (int i = 0; i < 10; i++) begin
            chk("done_gate", 128'({bus.ch_din_ready, bus.lut_din_valid}), 128'(0));
            step();
        end
        lut_prog_done = 1'b1;
        do_txn(0, 0);

        // reset while waiting for the core result
        vmask = '1;
        bus.ch_din_valid = vmask;
        #1;
        wait_ready(ok);
        chk("rst_grant_seen", 128'(ok), 128'(1));
        step();
        step();
        vmask = '0;
        bus.ch_din_valid = vmask;
        reset = 1'b1;
        step();
        chk_idle_outputs("rst_wait");
        chk("rst_wait_dout", 128'(bus.ch_dout), 128'(0));
        reset = 1'b0;
        for (int c = 0; c < N; c++) exp_dout[c] = '0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("late_result",
                128'({bus.ch_dout_valid, bus.lut_dout_ready, bus.ch_dout}),
                128'(0));
        end
        core_kill = 1'b1;
        step();
        core_kill = 1'b0;

        // enable=0 behaves as reset but keeps results
        vmask = 4'b0101;
        do_txn(0, 0);
        enable = 1'b0;
        repeat (2) step();
        chk_idle_outputs("disable");
        chk("disable_dout", 128'(bus.ch_dout), 128'(pack_exp()));
        enable = 1'b1;
        model_reset();

        // randomized traffic, inverting core
        core_inv = 1'b1;
        for (int i = 0; i < 30; i++) begin
            for (int c = 0; c < N; c++) bus.ch_din[c*DW +: DW] = DW'($urandom);
            vmask    = N'($urandom_range(1, (1 << N) - 1));
            pmask    = N'($urandom);
            core_lat = int'($urandom_range(1, 4));
            do_txn(int'($urandom_range(0, 2)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/interpolating_lut_channel_arbiter.md
Name: interpolating_lut_channel_arbiter

Overview:
- Shares one interpolating-LUT core (single outstanding sample, valid/ready streams) among G_NUM_CH independent sample streams, e.g. per-channel waveshaper/saturation stages.
- Gates all traffic until the LUT table is programmed.
- Selects requesters round-robin and keeps exactly one sample in flight.
- Returns each result only to the channel that issued the sample.

Parameters:
- G_NUM_CH, 4, number of requesting channels (2..16)
- G_DWIDTH, 24, sample width; must match the LUT core
- G_CNT_WIDTH, 16, width of the completed-transaction counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 behaves as reset, except that held ch_dout values are kept
- lut_prog_done  in  1  LUT table valid (core programming-done flag)
- ch_din  in  G_NUM_CH*G_DWIDTH  per-channel input samples; channel k in bits [k*DW +: DW]
- ch_din_valid  in  G_NUM_CH  per-channel input valid
- ch_din_ready  out  G_NUM_CH  per-channel input ready
- ch_dout  out  G_NUM_CH*G_DWIDTH  per-channel results, same packing as ch_din
- ch_dout_valid  out  G_NUM_CH  per-channel output valid
- ch_dout_ready  in  G_NUM_CH  per-channel output ready
- lut_din  out  G_DWIDTH  sample to the LUT core
- lut_din_valid  out  1  valid toward the LUT core
- lut_din_ready  in  1  ready from the LUT core
- lut_dout  in  G_DWIDTH  LUT core result
- lut_dout_valid  in  1  LUT core result valid
- lut_dout_ready  out  1  ready toward the LUT core
- active_ch  out  $clog2(G_NUM_CH)  currently granted channel
- busy  out  1  transaction in progress (ISSUE, WAIT or DELIVER state)
- xfer_count  out  G_CNT_WIDTH  completed transactions; wraps

Behaviour:
- Reset, or enable=0 (synchronous):
  - state WAIT_PROG; last_grant = G_NUM_CH-1, so channel 0 is checked first.
  - All valid/ready outputs, busy, active_ch and xfer_count are 0.
  - ch_dout is cleared by reset only; enable=0 holds it.
- WAIT_PROG: no channel is accepted. Move to ARB when lut_prog_done=1.
- ARB:
  - If lut_prog_done=0, return to WAIT_PROG.
  - Otherwise search ch_din_valid starting at (last_grant+1) mod G_NUM_CH and take the first set bit as grant g.
  - ch_din_ready[g]=1 combinationally in that cycle only. Register ch_din slice g into a sample register and g into active_ch, then go to ISSUE.
  - With no valid channel, stay in ARB with all ch_din_ready at 0.
- ISSUE: lut_din = sample register, lut_din_valid=1. On lut_din_ready=1, go to WAIT.
- WAIT: lut_dout_ready=1. On lut_dout_valid=1, register lut_dout into ch_dout slice g and go to DELIVER. No other slice changes.
- DELIVER:
  - ch_dout_valid[g]=1; all other valids are 0.
  - On ch_dout_ready[g]=1: last_grant=g, xfer_count+1 (wraps to 0), go to ARB.
  - ch_dout_ready on other channels is ignored.
- Outputs outside their state:
  - ch_din_ready, lut_din_valid, lut_dout_ready and ch_dout_valid are 0 outside their owning state.
  - lut_din is held at the last sample.
- Throughput: with a 1-cycle ready core and ready consumers, a transaction takes 4 cycles plus core latency.
- Only one sample is ever outstanding. Round-robin is fair: with every channel valid, each channel is served once per G_NUM_CH transactions.
- lut_prog_done falling during ISSUE, WAIT or DELIVER: the in-flight transaction completes normally. The drop is checked on the next ARB entry.
- A ch_din_valid falling before grant is allowed: it drops out of arbitration. A valid that is granted is consumed in the grant cycle.
- Reset or enable=0 mid-transaction: the in-flight sample is dropped, with no output valid and no count. An incomplete core result is ignored.
- Channel bits of ch_din_valid beyond G_NUM_CH do not exist. Unused ch_dout slices keep their last value.

Test Plan:
- lut_prog_done=0 with all ch_din_valid=1 for 20 cycles → ch_din_ready=0 and lut_din_valid=0 throughout. Set done=1 → channel 0 is granted first.
- Four channels all valid with values 0x000100, 0x000200, 0x000300, 0x000400; identity-model core with 2-cycle latency → grant order 0,1,2,3,0. Each ch_dout slice equals its own input; xfer_count=4 after the first round.
- Only channel 2 valid continuously → every grant goes to 2. Channel 1 asserted during channel 2's transaction → the next grant is channel 3 if valid, otherwise channel 1 (it must not be starved).
- ch_dout_ready[1]=0 for 10 cycles in DELIVER → ch_dout_valid[1] and data stay stable, no new grant, and lut_din_valid stays 0.
- lut_prog_done dropped in WAIT → the current result is still delivered, then the block enters WAIT_PROG and no new ch_din_ready occurs until done=1.
- Reset asserted in WAIT → the next cycle has all outputs 0 and xfer_count=0. The late lut_dout_valid is not forwarded.
